// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   master (MEM stage): drives mem_req, mem_we, mem_addr, mem_wdata;
//                       samples mem_rdata, mem_ack.
//   slave  (memory)   : the mirror image.
// mem_rdata is only meaningful in a cycle where mem_ack is high.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus the MEM/WB pipeline register.
//
// Takes the EX/MEM outputs, runs loads/stores over a req/ack data-memory
// bus and drives the register-file write port (wb_value/wb_dest/wb_en ->
// Result_WB/Dest_wb/writeBackEn). While an access is outstanding, freeze
// stalls every upstream stage and a bubble goes into MEM/WB.
//
// Ports
//   clk, rst          clock (posedge), asynchronous active-high reset
//   valid_in          EX/MEM holds a valid instruction
//   wb_en_in          instruction writes a register
//   mem_r_en_in       load (wins if mem_w_en_in is also set)
//   mem_w_en_in       store
//   alu_res_in        ALU result / byte address
//   st_val_in         store data
//   dest_in           destination register
//   freeze            combinational stall request to upstream stages
//   mem               data-memory bus, master side (mem_wb_stage_if)
//   wb_en/wb_dest/wb_value  registered register-file write port
//   error             sticky access-timeout flag
//
// Optional build macro MEM_TIMEOUT_EN: aborts an access after TIMEOUT
// cycles with no ack, sets error and suppresses that writeback. Without
// it an access waits indefinitely and error is tied low.
module mem_wb_stage #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic [31:0]          alu_res_in,
  input  logic [31:0]          st_val_in,
  input  logic [3:0]           dest_in,
  output logic                 freeze,
  mem_wb_stage_if.master       mem,
  output logic                 wb_en,
  output logic [3:0]           wb_dest,
  output logic [31:0]          wb_value,
  output logic                 error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Request captured on ACCESS entry and held for the whole access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } mem_req_t;

  state_t            state;
  mem_req_t          req_q;
  logic [31:0]       rdata_q;
  logic              mem_op;
  logic [ADDR_W-1:0] addr_next;
  logic              abort_q;

  assign mem_op    = valid_in & (mem_r_en_in | mem_w_en_in);
  assign addr_next = ADDR_W'((alu_res_in - 32'(BASE_ADDR)) >> 2);

  // Low in DONE so the stalled instruction advances exactly once.
  assign freeze = ((state == IDLE) & mem_op) | (state == ACCESS);

  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_we    = req_q.we;
  assign mem.mem_addr  = req_q.addr;
  assign mem.mem_wdata = req_q.wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
`else
  assign abort_q = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt     <= '0;
      abort_q <= 1'b0;
      error   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state       <= ACCESS;
            req_q.we    <= ~mem_r_en_in;
            req_q.addr  <= addr_next;
            req_q.wdata <= st_val_in;
`ifdef MEM_TIMEOUT_EN
            cnt         <= '0;
`endif
          end
        end
        ACCESS: begin
          // An ack in the limit cycle takes priority over the abort.
          if (mem.mem_ack) begin
            state <= DONE;
            if (!req_q.we) rdata_q <= mem.mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == LIMIT) begin
            state   <= DONE;
            rdata_q <= '0;
            abort_q <= 1'b1;
            error   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef MEM_TIMEOUT_EN
          // Still seen by the MEM/WB register at this same edge.
          abort_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: outputs only change at posedge, so the negedge
  // register-file write always sees stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en    <= 1'b0;
      wb_dest  <= '0;
      wb_value <= '0;
    end else if (freeze) begin
      wb_en <= 1'b0;
    end else begin
      wb_en    <= valid_in & wb_en_in & ~abort_q;
      wb_dest  <= dest_in;
      wb_value <= mem_r_en_in ? rdata_q : alu_res_in;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  localparam int ADDR_W = 8;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, st_val_in;
  logic [3:0]  dest_in;
  logic        freeze, wb_en, error;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) bus();

  mem_wb_stage #(.ADDR_W(ADDR_W), .BASE_ADDR(1024), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .freeze(freeze), .mem(bus), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural memory as the program sees it, and the memory behind the bus.
  logic [31:0] ref_mem [int];
  logic [31:0] bus_mem [int];

  function automatic logic [31:0] seed_val(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
  endfunction
  function automatic logic [31:0] bus_rd(int a);
    return bus_mem.exists(a) ? bus_mem[a] : seed_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    @(negedge clk);
  endtask

  // Issue one instruction at the current negedge and hold it while frozen.
  // Returns at the negedge after it entered MEM/WB, with outputs checked.
  task automatic do_op(input logic v, input logic we_in, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] st,
                       input logic [3:0] d, input int wait_n);
    int idx, fz, rq;
    logic is_mem, tmo, exp_en, done;
    logic [31:0] exp_val;
    is_mem = v & (r | w);
    idx = int'(((alu - 32'd1024) >> 2) % (1 << ADDR_W));
`ifdef MEM_TIMEOUT_EN
    tmo = is_mem && (wait_n >= TMO);
`else
    tmo = 1'b0;
`endif
    exp_en = v & we_in & ~tmo;
    if (is_mem && r) exp_val = ref_rd(idx);
    else             exp_val = alu;
    if (is_mem && !r && !tmo) ref_mem[idx] = st;

    valid_in = v; wb_en_in = we_in; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; st_val_in = st; dest_in = d;
    fz = 0; rq = 0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (bus.mem_req) begin
        chk("mem_addr", 32'(bus.mem_addr), idx);
        chk("mem_we", 32'(bus.mem_we), 32'(!r));
        chk("mem_wdata", bus.mem_wdata, st);
        if (rq == wait_n) begin
          bus.mem_ack = 1'b1;
          if (!bus.mem_we) bus.mem_rdata = bus_rd(int'(bus.mem_addr));
          else bus_mem[int'(bus.mem_addr)] = bus.mem_wdata;
        end
        rq++;
      end
      if (!freeze) begin
        done = 1'b1;
        break;
      end
      fz++;
      if (fz > 1) chk("stall_wb_en", 32'(wb_en), 0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_bound: freeze still high after 200 cycles");
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("wb_en", 32'(wb_en), 32'(exp_en));
    if (exp_en) begin
      chk("wb_dest", 32'(wb_dest), 32'(d));
      chk("wb_value", wb_value, exp_val);
    end
    chk("freeze_cycles", fz, !is_mem ? 0 : (tmo ? TMO + 1 : wait_n + 2));
    chk("req_cycles", rq, !is_mem ? 0 : (tmo ? TMO : wait_n + 1));
    if (tmo) chk("error_set", 32'(error), 1);
  endtask

  task automatic rand_op();
    int kind, wait_n, word;
    logic [31:0] addr;
    kind   = $urandom_range(0, 5);
    wait_n = $urandom_range(0, 4);
`ifdef MEM_TIMEOUT_EN
    if ($urandom_range(0, 9) == 0) wait_n = NEVER;
    if ($urandom_range(0, 9) == 0) wait_n = TMO - 1;
`endif
    word = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 15);
    addr = 32'd1024 + 32'(word) * 4 + 32'($urandom_range(0, 3));
    case (kind)
      0: do_op(1, 1, 0, 0, $urandom, $urandom, 4'($urandom), 0);
      1: do_op(1, $urandom_range(0, 1), 1, 0, addr, $urandom, 4'($urandom), wait_n);
      2: do_op(1, 0, 0, 1, addr, $urandom, 4'($urandom), wait_n);
      3: do_op(1, 1, 1, 1, addr, $urandom, 4'($urandom), wait_n);
      4: do_op(0, 1, 1, $urandom_range(0, 1), addr, $urandom, 4'($urandom), wait_n);
      default: do_op(1, 1, 0, 1, addr, $urandom, 4'($urandom), wait_n);
    endcase
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = 0; st_val_in = 0; dest_in = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #12;
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_error", 32'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU op: no stall, one-cycle writeback.
    do_op(1, 1, 0, 0, 32'h2A, 0, 4'd3, 0);
    // Zero-wait load from word 2.
    ref_mem[2] = 32'hDEAD_BEEF; bus_mem[2] = 32'hDEAD_BEEF;
    do_op(1, 1, 1, 0, 32'd1032, 0, 4'd5, 0);
    // Store with three wait cycles, no writeback.
    do_op(1, 0, 0, 1, 32'd1028, 32'h55, 4'd6, 3);
    idle();
    // Back-to-back zero-wait loads: only the DONE cycle is freeze-free.
    do_op(1, 1, 1, 0, 32'd1024, 0, 4'd1, 0);
    do_op(1, 1, 1, 0, 32'd1036, 0, 4'd2, 0);
    // Load reads back the earlier store through the bus.
    do_op(1, 1, 1, 0, 32'd1028, 0, 4'd8, 1);

    // Reset in the middle of an access, late ack afterwards.
    valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 1;
    alu_res_in = 32'd1040; st_val_in = 32'h1234_5678; dest_in = 4'd9;
    @(negedge clk);
    #1;
    chk("mid_req", 32'(bus.mem_req), 1);
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 0);
    chk("arst_mem_we", 32'(bus.mem_we), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk("arst_mem_wdata", bus.mem_wdata, 0);
    chk("arst_wb_en", 32'(wb_en), 0);
    chk("arst_wb_dest", 32'(wb_dest), 0);
    chk("arst_wb_value", wb_value, 0);
    valid_in = 0; wb_en_in = 0; mem_w_en_in = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    #1;
    chk("late_ack_req", 32'(bus.mem_req), 0);
    chk("late_ack_freeze", 32'(freeze), 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("late_ack_wb_en", 32'(wb_en), 0);
      chk("late_ack_req_idle", 32'(bus.mem_req), 0);
      @(negedge clk);
    end

`ifdef MEM_TIMEOUT_EN
    // Never-acked load aborts after TMO request cycles.
    do_op(1, 1, 1, 0, 32'd1044, 0, 4'd9, NEVER);
    do_op(1, 1, 0, 0, 32'h77, 0, 4'd4, 0);
    chk("error_sticky", 32'(error), 1);
    // Ack in the limit cycle wins.
    do_op(1, 1, 1, 0, 32'd1048, 0, 4'd10, TMO - 1);
`endif

    for (int n = 0; n < 60; n++) begin
      rand_op();
      if ($urandom_range(0, 2) == 0) idle();
    end

`ifndef MEM_TIMEOUT_EN
    chk("error_tied_low", 32'(error), 0);
`endif
    idle();
    rst = 1'b1;
    #1;
    chk("final_rst_error", 32'(error), 0);
    chk("final_rst_wb_en", 32'(wb_en), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the ARM core.
- Consumes EX/MEM outputs and performs loads/stores over a req/ack data-memory handshake.
- Stalls the pipeline while an access is outstanding.
- Drives the register-file write port: wb_value, wb_dest, wb_en map to Result_WB, Dest_wb, writeBackEn.

Parameters:
- ADDR_W, 8, word-address width of mem_addr.
- BASE_ADDR, 1024, byte base of data memory, subtracted from the ALU result.
- TIMEOUT, 16, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  EX/MEM holds a valid instruction.
- wb_en_in  in  1  instruction writes a register.
- mem_r_en_in  in  1  load.
- mem_w_en_in  in  1  store.
- alu_res_in  in  32  ALU result / byte address.
- st_val_in  in  32  store data.
- dest_in  in  4  destination register.
- freeze  out  1  stall request to all upstream stages.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  access complete.
- wb_en  out  1  register-file write enable.
- wb_dest  out  4  register-file write index.
- wb_value  out  32  register-file write data.
- error  out  1  sticky access-timeout flag.

Behaviour:
- mem_op = valid_in & (mem_r_en_in | mem_w_en_in). If both enables are high, treat as a load and ignore the store.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS when mem_op. At that edge register mem_addr = (alu_res_in - BASE_ADDR) >> 2, truncated to ADDR_W bits; mem_wdata = st_val_in; mem_we = ~mem_r_en_in.
  - ACCESS -> DONE on the first cycle mem_ack = 1. rdata_q captures mem_rdata for loads.
  - DONE -> IDLE unconditionally.
- mem_req = (state == ACCESS), a pure decode of registered state.
- Address and data are held stable for the whole of ACCESS.
- mem_ack outside ACCESS is ignored.
- freeze = (state == IDLE & mem_op) | (state == ACCESS). It is combinational, and is 0 in DONE so the instruction advances exactly once.
- MEM/WB register, updated on posedge:
  - if freeze: wb_en <= 0 (bubble); wb_dest and wb_value hold.
  - else: wb_en <= valid_in & wb_en_in; wb_dest <= dest_in; wb_value <= (mem_r_en_in ? rdata_q : alu_res_in).
- Stores never write back unless wb_en_in is set, in which case wb_value = alu_res_in.
- Latency:
  - non-memory instruction: 1 cycle to the wb outputs, no stall.
  - load/store with ack after N wait cycles (N = 0 means ack in the first ACCESS cycle): freeze high for N+2 cycles; wb outputs valid at the edge ending DONE.
- Back-to-back memory instructions: DONE -> IDLE, then the next op starts in IDLE. There is one freeze-free cycle (DONE) between them.
- Reset (any time, including mid-ACCESS), all values immediate:
  - state = IDLE; mem_req = 0; mem_we = 0.
  - mem_addr, mem_wdata, rdata_q = 0.
  - wb_en = 0, wb_dest = 0, wb_value = 0, error = 0.
  - A pending access is abandoned; a late ack is ignored.
- The register file writes on negedge clk, so wb outputs must be stable from posedge to posedge. No combinational path from inputs to wb outputs.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack: go to DONE, rdata_q = 0, error <= 1 (sticky until rst), and that instruction's writeback is forced to wb_en = 0.
  - An ack in the same cycle as the limit wins, and no error is raised.
- Without the macro: no counter, ACCESS waits indefinitely, error tied to 0.

Test Plan:
- ALU op: valid_in=1, wb_en_in=1, alu_res_in=0x2A, dest_in=3 -> freeze stays 0; next edge wb_en=1, wb_dest=3, wb_value=0x2A.
- Zero-wait load:
  - Stimulus: alu_res_in=1032, dest_in=5; memory acks in the first ACCESS cycle with rdata=0xDEADBEEF.
  - Response: mem_addr=2, mem_we=0; freeze high 2 cycles; then wb_en=1, wb_dest=5, wb_value=0xDEADBEEF; wb_en=0 during the stall.
- Store with 3-wait ack:
  - Stimulus: alu_res_in=1028, st_val_in=0x55, wb_en_in=0.
  - Response: mem_req high 4 cycles with mem_addr=1, mem_we=1, mem_wdata=0x55 stable; freeze high 5 cycles; wb_en stays 0.
- Back-to-back loads to 1024 and 1036, each zero-wait -> two separate ACCESS phases (mem_addr 0 then 3); freeze drops exactly one cycle between them; both writebacks occur in order.
- rst pulsed during ACCESS with ack arriving 1 cycle after rst release -> mem_req=0 and all outputs 0 immediately; FSM stays IDLE; late ack causes no writeback.
- MEM_TIMEOUT_EN with TIMEOUT=4, ack never asserted -> mem_req high 4 cycles, error=1 afterwards, wb_en=0 for that load; error persists until rst.
